// File: rtl/pw_attempt_ctrl.sv
// Password attempt controller: synchronizes the keypad inputs, presents one
// character per enter press to the password FSM, counts failures, locks out.
module pw_attempt_ctrl #(
    parameter int MAX_TRIES    = 3,
    parameter int LOCK_CYCLES  = 1024,
    parameter int RESP_TIMEOUT = 16,
    parameter int CLR_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] char_in,
    input  logic       enter_in,
    input  logic       relock,
    input  logic       fsm_open,
    input  logic       fsm_wrong,
    output logic [6:0] fsm_char,
    output logic       fsm_enter,
    output logic       fsm_rst_n,
    output logic       open,
    output logic       wrong,
    output logic       lockout,
    output logic [3:0] tries
);

    localparam int TMAX_RC = (RESP_TIMEOUT > CLR_CYCLES) ? RESP_TIMEOUT : CLR_CYCLES;
    localparam int TMAX    = (LOCK_CYCLES > TMAX_RC) ? LOCK_CYCLES : TMAX_RC;
    localparam int TW      = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        WAIT,
        OPEN,
        CLEAR,
        LOCK
    } state_t;

    state_t        state;
    logic [6:0]    char_s1;
    logic [6:0]    char_s2;
    logic          enter_s1;
    logic          enter_s2;
    logic          enter_d;
    logic          enter_evt;
    logic [TW-1:0] timer;
    logic [3:0]    tries_inc;
    logic          last_try;

    assign enter_evt = enter_s2 & ~enter_d;
    assign tries_inc = (tries >= 4'(MAX_TRIES)) ? 4'(MAX_TRIES) : tries + 4'd1;
    assign last_try  = ({1'b0, tries} + 5'd1) >= 5'(MAX_TRIES);

    // Two-flop synchronizers; enter idles high so a button held through reset is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            char_s1  <= '0;
            char_s2  <= '0;
            enter_s1 <= 1'b1;
            enter_s2 <= 1'b1;
            enter_d  <= 1'b1;
        end else begin
            char_s1  <= char_in;
            char_s2  <= char_s1;
            enter_s1 <= enter_in;
            enter_s2 <= enter_s1;
            enter_d  <= enter_s2;
        end
    end

    // Attempt sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fsm_char  <= '0;
            fsm_enter <= 1'b0;
            fsm_rst_n <= 1'b0;
            open      <= 1'b0;
            wrong     <= 1'b0;
            lockout   <= 1'b0;
            tries     <= '0;
            timer     <= '0;
        end else begin
            fsm_enter <= 1'b0;
            unique case (state)
                IDLE: begin
                    fsm_rst_n <= 1'b1;
                    if (enter_evt) begin
                        fsm_char  <= char_s2;
                        fsm_enter <= 1'b1;
                        wrong     <= 1'b0;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    timer <= TW'(RESP_TIMEOUT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (fsm_open && !fsm_wrong) begin
                        tries <= '0;
                        open  <= 1'b1;
                        state <= OPEN;
                    end else if (fsm_wrong || timer == TW'(1)) begin
                        tries     <= tries_inc;
                        wrong     <= 1'b1;
                        fsm_rst_n <= 1'b0;
                        if (last_try) begin
                            lockout <= 1'b1;
                            timer   <= TW'(LOCK_CYCLES);
                            state   <= LOCK;
                        end else begin
                            timer <= TW'(CLR_CYCLES);
                            state <= CLEAR;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                OPEN: begin
                    if (relock) begin
                        open      <= 1'b0;
                        fsm_rst_n <= 1'b0;
                        timer     <= TW'(CLR_CYCLES);
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (timer == TW'(1)) begin
                        timer     <= '0;
                        fsm_rst_n <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                LOCK: begin
                    if (timer == TW'(1)) begin
                        timer     <= '0;
                        tries     <= '0;
                        wrong     <= 1'b0;
                        lockout   <= 1'b0;
                        fsm_rst_n <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_attempt_ctrl.sv
// Bench for pw_attempt_ctrl: acts as keypad and password FSM, predicts
// outcomes per attempt from the failure-count rules.
module tb_pw_attempt_ctrl;

    localparam int MT   = 3;
    localparam int LOCK = 1024;
    localparam int RESP = 16;
    localparam int CLR  = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] char_in;
    logic       enter_in;
    logic       relock;
    logic       fsm_open;
    logic       fsm_wrong;
    logic [6:0] fsm_char;
    logic       fsm_enter;
    logic       fsm_rst_n;
    logic       open;
    logic       wrong;
    logic       lockout;
    logic [3:0] tries;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_tries = 0;
    int abort_at = 0;

    pw_attempt_ctrl #(
        .MAX_TRIES(MT),
        .LOCK_CYCLES(LOCK),
        .RESP_TIMEOUT(RESP),
        .CLR_CYCLES(CLR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .char_in(char_in),
        .enter_in(enter_in),
        .relock(relock),
        .fsm_open(fsm_open),
        .fsm_wrong(fsm_wrong),
        .fsm_char(fsm_char),
        .fsm_enter(fsm_enter),
        .fsm_rst_n(fsm_rst_n),
        .open(open),
        .wrong(wrong),
        .lockout(lockout),
        .tries(tries)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, required finish before 5 ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_char", int'(fsm_char), 0);
        chk("rst_enter", int'(fsm_enter), 0);
        chk("rst_fsm_rst_n", int'(fsm_rst_n), 0);
        chk("rst_open", int'(open), 0);
        chk("rst_wrong", int'(wrong), 0);
        chk("rst_lockout", int'(lockout), 0);
        chk("rst_tries", int'(tries), 0);
    endtask

    // Entered on the first negedge with fsm_rst_n low after a failure or relock
    task automatic measure_clear();
        int n;
        n = 0;
        chk("clear_no_lock", int'(lockout), 0);
        while (!fsm_rst_n && n < CLR + 5) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", n, CLR);
    endtask

    task automatic measure_lock();
        int n;
        bit saw;
        bit bad;
        n = 0;
        saw = 0;
        bad = 0;
        chk("lock_on", int'(lockout), 1);
        chk("lock_rst_n", int'(fsm_rst_n), 0);
        while (lockout && n < LOCK + 10) begin
            n++;
            if (n == abort_at) begin
                #2 reset_n = 1'b0;
                #1 check_reset_vals();
                @(negedge clk);
                reset_n = 1'b1;
                exp_tries = 0;
                abort_at = 0;
                @(negedge clk);
                chk("abort_rst_n_up", int'(fsm_rst_n), 1);
                chk("abort_lockout", int'(lockout), 0);
                return;
            end
            if (n == 100 || n == 700) enter_in = 1'b1;
            if (n == 104 || n == 702) enter_in = 1'b0;
            if (fsm_enter) saw = 1;
            if (int'(tries) != MT) bad = 1;
            @(negedge clk);
        end
        chk("lock_len", n, LOCK);
        chk("lock_tries_held", int'(bad), 0);
        chk("unlock_tries", int'(tries), 0);
        chk("unlock_wrong", int'(wrong), 0);
        chk("unlock_rst_n", int'(fsm_rst_n), 1);
        exp_tries = 0;
        repeat (6) begin
            if (fsm_enter) saw = 1;
            @(negedge clk);
        end
        chk("lock_ignore", int'(saw), 0);
    endtask

    // kind: 0 open, 1 wrong, 2 open+wrong, 3 silent; k = WAIT cycle of verdict
    task automatic do_attempt(input logic [6:0] ch, input int kind, input int k);
        bit got;
        int n;
        char_in = ch;
        enter_in = 1'b1;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (fsm_enter) got = 1;
        end
        chk("enter_seen", int'(got), 1);
        if (!got) begin
            enter_in = 1'b0;
            return;
        end
        chk("fsm_char", int'(fsm_char), int'(ch));
        chk("wrong_clr", int'(wrong), 0);
        enter_in = 1'b0;
        if (kind == 3) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) chk("enter_1cyc", int'(fsm_enter), 0);
            end while (fsm_rst_n && n < RESP + 5);
            chk("wait_len", n, RESP + 1);
        end else begin
            for (int c = 1; c <= k; c++) begin
                @(negedge clk);
                if (c == 1) chk("enter_1cyc", int'(fsm_enter), 0);
                if (c == k) begin
                    fsm_open  = (kind == 0 || kind == 2);
                    fsm_wrong = (kind == 1 || kind == 2);
                end
            end
            @(negedge clk);
            fsm_open  = 1'b0;
            fsm_wrong = 1'b0;
        end
        if (kind == 0) begin
            exp_tries = 0;
            chk("open", int'(open), 1);
            chk("open_tries", int'(tries), 0);
            chk("open_wrong", int'(wrong), 0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            chk("open_hold", int'(open), 1);
            relock = 1'b1;
            @(negedge clk);
            relock = 1'b0;
            chk("relock_open", int'(open), 0);
            measure_clear();
        end else begin
            exp_tries = (exp_tries + 1 > MT) ? MT : exp_tries + 1;
            chk("fail_open", int'(open), 0);
            chk("fail_tries", int'(tries), exp_tries);
            chk("fail_wrong", int'(wrong), 1);
            chk("fail_rst_n", int'(fsm_rst_n), 0);
            if (exp_tries == MT) measure_lock();
            else measure_clear();
        end
    endtask

    initial begin
        bit saw;
        reset_n   = 1'b0;
        char_in   = '0;
        enter_in  = 1'b1;
        relock    = 1'b0;
        fsm_open  = 1'b0;
        fsm_wrong = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_n_first_edge", int'(fsm_rst_n), 1);
        saw = 0;
        repeat (10) begin
            if (fsm_enter) saw = 1;
            @(negedge clk);
        end
        chk("held_enter_no_evt", int'(saw), 0);
        enter_in = 1'b0;
        repeat (4) @(negedge clk);

        do_attempt(7'h2A, 0, 3);
        do_attempt(7'h11, 3, 1);
        do_attempt(7'h33, 2, 5);
        chk("both_tries", exp_tries, 2);
        do_attempt(7'h05, 0, 1);
        do_attempt(7'h41, 1, 2);
        do_attempt(7'h42, 1, 7);
        do_attempt(7'h43, 1, 16);

        do_attempt(7'h01, 1, 1);
        do_attempt(7'h02, 1, 4);
        abort_at = 500;
        do_attempt(7'h03, 3, 1);
        repeat (3) @(negedge clk);
        do_attempt(7'h7F, 0, 2);

        for (int i = 0; i < 25; i++) begin
            do_attempt(7'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(1, RESP)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pw_attempt_ctrl.md
PW_ATTEMPT_CTRL -- requirements
Module: pw_attempt_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3, consecutive failures before lockout (1..15).
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024, lockout duration in clk cycles (>=1).
REQ-003 SHALL have parameter RESP_TIMEOUT, default 16, max cycles to wait for an FSM verdict (>=1).
REQ-004 SHALL have parameter CLR_CYCLES, default 2, cycles fsm_rst_n is held low when re-arming the FSM (>=1).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port char_in  input  7  raw password character from the PMOD header.
REQ-008 SHALL have port enter_in  input  1  raw, asynchronous enter button.
REQ-009 SHALL have port relock  input  1  level; closes the lock from OPEN.
REQ-010 SHALL have port fsm_open  input  1  open verdict from the password FSM.
REQ-011 SHALL have port fsm_wrong  input  1  wrong verdict from the password FSM.
REQ-012 SHALL have port fsm_char  output  7  registered character presented to the FSM.
REQ-013 SHALL have port fsm_enter  output  1  one-cycle enter strobe to the FSM.
REQ-014 SHALL have port fsm_rst_n  output  1  active-low reset to the FSM.
REQ-015 SHALL have port open  output  1  lock-open indicator.
REQ-016 SHALL have port wrong  output  1  last-attempt-failed indicator.
REQ-017 SHALL have port lockout  output  1  lockout active.
REQ-018 SHALL have port tries  output  4  consecutive failure count.

Function
REQ-019 SHALL pass enter_in and char_in through two-flop synchronizers; the enter synchronizer flops SHALL reset to 1.
REQ-020 SHALL form enter_evt as a rising edge of synchronized enter; a button held through reset release SHALL produce no event until released and re-pressed.
REQ-021 SHALL implement states IDLE, PRESENT, WAIT, OPEN, CLEAR, LOCK.
REQ-022 SHALL in IDLE, on enter_evt, capture the synchronized char into fsm_char, clear wrong, and go to PRESENT.
REQ-023 SHALL in PRESENT assert fsm_enter for exactly one cycle, load the response timer with RESP_TIMEOUT, and go to WAIT.
REQ-024 SHALL in WAIT, on fsm_open=1 with fsm_wrong=0, set tries=0 and go to OPEN.
REQ-025 SHALL in WAIT, on fsm_wrong=1, on fsm_open and fsm_wrong both 1 (fail-secure), or on timer expiry, count a failure: tries+1, wrong=1.
REQ-026 SHALL on a failure go to LOCK with the timer loaded to LOCK_CYCLES when tries+1 == MAX_TRIES, else go to CLEAR.
REQ-027 SHALL in OPEN hold open=1; on relock=1 deassert open and go to CLEAR.
REQ-028 SHALL in CLEAR drive fsm_rst_n=0 for exactly CLR_CYCLES cycles, then return to IDLE.
REQ-029 SHALL in LOCK hold lockout=1 and fsm_rst_n=0; after LOCK_CYCLES cycles set tries=0, wrong=0, and go to IDLE.
REQ-030 SHALL drop enter_evt in every state except IDLE, with no queuing.
REQ-031 SHALL change fsm_char only on an accepted enter_evt.
REQ-032 SHALL saturate tries at MAX_TRIES and never wrap.
REQ-033 SHALL drive all outputs from registers, with no combinational paths from inputs to outputs.

Reset
REQ-034 SHALL on reset_n=0 asynchronously force state=IDLE, fsm_char=0, fsm_enter=0, fsm_rst_n=0, open=0, wrong=0, lockout=0, tries=0, timers=0.
REQ-035 SHALL drive fsm_rst_n=1 from the first clk edge after reset_n deasserts.
REQ-036 SHALL abort any operation, including LOCK, when reset is asserted mid-operation; lockout and tries SHALL clear.

Verification
REQ-037 SHALL verify: char 0x2A, enter pressed, FSM answers open on WAIT cycle 3 -> fsm_enter one pulse with fsm_char=0x2A, open=1, tries=0; relock -> open=0, fsm_rst_n low 2 cycles.
REQ-038 SHALL verify: three wrong verdicts with defaults -> tries 1, 2, 3; wrong=1; lockout=1 for 1024 cycles; enter presses during lockout ignored; then tries=0 and lockout=0.
REQ-039 SHALL verify: FSM silent after enter -> failure after 16 WAIT cycles, tries=1, state CLEAR.
REQ-040 SHALL verify: fsm_open and fsm_wrong asserted in the same cycle -> counted as failure, open stays 0.
REQ-041 SHALL verify: enter held across reset release -> no fsm_enter until release and re-press.
REQ-042 SHALL verify: reset_n pulsed low at LOCK cycle 500 -> all outputs at reset values immediately, next enter accepted.
